register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: size, default 32, data width of every register and data port.
REQ-002 Parameter: addr_width, default 5, register select width; depth SHALL be 2**addr_width (32 registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 read_sel_1  input  addr_width  register index for read port 1.
REQ-006 read_sel_2  input  addr_width  register index for read port 2.
REQ-007 write_en  input  1  write strobe, sampled at rising clk.
REQ-008 write_sel  input  addr_width  register index for write port.
REQ-009 write_data  input  size  value written when write_en=1.
REQ-010 read_data_1  output  size  contents of register read_sel_1; drives in_0 of downstream operand select mux.
REQ-011 read_data_2  output  size  contents of register read_sel_2; drives in_0 of downstream ALU-source select mux.

Function
REQ-012 Storage: 2**addr_width registers of size bits, each updated only on rising clk.
REQ-013 Reads SHALL be combinational: read_data_N follows read_sel_N and register contents with zero-cycle latency, no clock involved.
REQ-014 Write: at rising clk with rst=0, write_en=1, write_sel!=0 -> reg[write_sel] <= write_data; new value visible on reads after that edge.
REQ-015 write_en=0 at rising clk -> no register changes; write_sel/write_data ignored.
REQ-016 Register 0 SHALL read as all-zeros on both ports at all times; writes to index 0 discarded.
REQ-017 Both read ports independent; read_sel_1==read_sel_2 -> both outputs identical.
REQ-018 Same-cycle read and write of same nonzero index: output governed by REQ-025/REQ-026.
REQ-019 Out-of-range indices impossible by construction (full decode of addr_width bits); no X on outputs for any select value once reset applied.
REQ-020 Only one write per cycle; no write-port arbitration required.

Reset
REQ-021 Rising clk with rst=1 SHALL clear all registers to 0; rst has priority over write_en (write in reset cycle is dropped).
REQ-022 Reset asserted mid-operation: contents cleared on first rising edge with rst=1; reads in that same cycle (before edge) still show pre-reset values.
REQ-023 After reset, both read outputs = 0 for every select value until a write occurs.
REQ-024 rst has no asynchronous effect; deasserting rst between edges changes nothing.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN defined: when write_en=1, rst=0, write_sel!=0 and read_sel_N==write_sel, read_data_N SHALL equal write_data combinationally in the same cycle (write-through forwarding).
REQ-026 REGFILE_BYPASS_EN undefined: read_data_N in that case SHALL return the stored (old) value; new value visible only after the edge.
REQ-027 Bypass SHALL never forward to index 0 nor during rst=1.

Verification
REQ-028 Assert rst=1 one edge, release; sweep read_sel_1/2 over 0..31 -> all reads 0x00000000.
REQ-029 Write 0xDEADBEEF to reg 5, then read_sel_1=5, read_sel_2=5 -> both 0xDEADBEEF; reg 6 still 0.
REQ-030 write_en=1, write_sel=0, write_data=0xFFFFFFFF, edge -> read_sel_1=0 returns 0x00000000.
REQ-031 Reg 7 holds 0x11111111; same cycle write_sel=7, write_data=0x22222222, read_sel_2=7 -> before edge read_data_2=0x22222222 with REGFILE_BYPASS_EN, 0x11111111 without; after edge 0x22222222 in both builds.
REQ-032 Reg 3 holds 0x0000ABCD; rst=1 and write_en=1, write_sel=3, write_data=0x12345678 same edge -> after edge reg 3 reads 0x00000000.
REQ-033 write_en=0, write_sel=9, write_data=0xCAFEF00D, edge -> reg 9 unchanged at 0x00000000.

Source files
------------

// File: rtl/register_file.sv
// Register file with two combinational read ports and one synchronous write port;
// register 0 is hardwired to zero. Optional write-through forwarding: REGFILE_BYPASS_EN.
module register_file #(
  parameter int size       = 32,
  parameter int addr_width = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] read_sel_1,
  input  logic [addr_width-1:0] read_sel_2,
  input  logic                  write_en,
  input  logic [addr_width-1:0] write_sel,
  input  logic [size-1:0]       write_data,
  output logic [size-1:0]       read_data_1,
  output logic [size-1:0]       read_data_2
);

  localparam int depth = 2 ** addr_width;

  logic [size-1:0] regs [depth];
  logic            write_ok;

  // Writes to index 0 are discarded, so reg 0 never holds anything but zero after reset.
  assign write_ok = write_en && (write_sel != '0);

  // NOTE: every register is cleared in reset, which keeps this a flop array rather
  // than an inferable RAM; that is intended, since a full synchronous clear is required.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[write_sel] <= write_data;
    end
  end

  // Reg 0 is forced to zero on the read side too, so it is clean even before reset.
  function automatic logic [size-1:0] read_port(input logic [addr_width-1:0] sel);
    logic [size-1:0] value;
    value = '0;
    if (sel != '0) begin
      value = regs[sel];
`ifdef REGFILE_BYPASS_EN
      if (!rst && write_ok && (sel == write_sel)) begin
        value = write_data;
      end
`endif
    end
    return value;
  endfunction

  // NOTE: combinational outputs are assigned unconditionally from a function with a
  // defaulted local, so no path leaves them unassigned and no latch is inferred.
  always_comb begin
    read_data_1 = read_port(read_sel_1);
    read_data_2 = read_port(read_sel_2);
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table plus hand sequences
// for reset sweep, write-in-reset and rst glitches between edges.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  read_sel_1;
  logic [4:0]  read_sel_2;
  logic        write_en;
  logic [4:0]  write_sel;
  logic [31:0] write_data;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;

  int checks   = 0;
  int failures = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit bypass_build = 1'b1;
`else
  localparam bit bypass_build = 1'b0;
`endif

  register_file #(.size(32), .addr_width(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .read_sel_1  (read_sel_1),
    .read_sel_2  (read_sel_2),
    .write_en    (write_en),
    .write_sel   (write_sel),
    .write_data  (write_data),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pre1/pre2: stored (old) value seen before the edge; bypass is layered on by pre_exp().
  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  ws;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pre1;
    logic [31:0] pre2;
    logic [31:0] post1;
    logic [31:0] post2;
  } vec_t;

  localparam int num_vecs = 10;
  vec_t vecs [num_vecs];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pre_exp(input vec_t v, input logic [4:0] rs,
                                          input logic [31:0] stored);
    if (bypass_build && !v.rst && v.we && (v.ws != 5'd0) && (rs == v.ws))
      return v.wd;
    return stored;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic apply(input vec_t v, input int idx);
    rst        = v.rst;
    write_en   = v.we;
    write_sel  = v.ws;
    write_data = v.wd;
    read_sel_1 = v.rs1;
    read_sel_2 = v.rs2;
    #2;
    check($sformatf("vec%0d_pre_rd1", idx), read_data_1, pre_exp(v, v.rs1, v.pre1));
    check($sformatf("vec%0d_pre_rd2", idx), read_data_2, pre_exp(v, v.rs2, v.pre2));
    @(posedge clk);
    #1;
    check($sformatf("vec%0d_post_rd1", idx), read_data_1, v.post1);
    check($sformatf("vec%0d_post_rd2", idx), read_data_2, v.post2);
  endtask

  task automatic sweep_zero(input string tag);
    rst      = 1'b0;
    write_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_sel_1 = 5'(i);
      read_sel_2 = 5'(31 - i);
      #2;
      check($sformatf("%s_rd1_sel%0d", tag, i), read_data_1, 32'h0);
      check($sformatf("%s_rd2_sel%0d", tag, 31 - i), read_data_2, 32'h0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    //            rst  we   ws     wd            rs1    rs2    pre1          pre2          post1         post2
    vecs[0] = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 5'd7,  32'h11111111, 5'd1,  5'd2,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[4] = '{1'b0, 1'b1, 5'd7,  32'h22222222, 5'd5,  5'd7,  32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF, 32'h22222222};
    vecs[5] = '{1'b0, 1'b0, 5'd9,  32'hCAFEF00D, 5'd9,  5'd7,  32'h0,        32'h22222222, 32'h0,        32'h22222222};
    vecs[6] = '{1'b0, 1'b1, 5'd3,  32'h0000ABCD, 5'd3,  5'd3,  32'h0,        32'h0,        32'h0000ABCD, 32'h0000ABCD};
    vecs[7] = '{1'b1, 1'b1, 5'd3,  32'h12345678, 5'd3,  5'd5,  32'h0000ABCD, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[8] = '{1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 32'h0,        32'h0,        32'hA5A5A5A5, 32'h0};
    vecs[9] = '{1'b0, 1'b1, 5'd30, 32'h5A5A5A5A, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h5A5A5A5A};

    rst        = 1'b0;
    write_en   = 1'b0;
    write_sel  = 5'd0;
    write_data = 32'h0;
    read_sel_1 = 5'd0;
    read_sel_2 = 5'd0;
    @(posedge clk);
    #1;

    // Reg 0 reads zero even before any reset.
    #2;
    check("pre_reset_reg0_rd1", read_data_1, 32'h0);
    check("pre_reset_reg0_rd2", read_data_2, 32'h0);

    // One reset edge with a write that must be dropped, then full zero sweep.
    rst        = 1'b1;
    write_en   = 1'b1;
    write_sel  = 5'd12;
    write_data = 32'hFFFF0000;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    write_en = 1'b0;
    sweep_zero("after_reset");

    for (int i = 0; i < num_vecs; i++) begin
      apply(vecs[i], i);
    end

    // rst pulsed between edges must have no effect.
    write_en   = 1'b0;
    read_sel_1 = 5'd31;
    read_sel_2 = 5'd30;
    rst        = 1'b1;
    #2;
    check("rst_glitch_pre_rd1", read_data_1, 32'hA5A5A5A5);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_glitch_post_rd1", read_data_1, 32'hA5A5A5A5);
    check("rst_glitch_post_rd2", read_data_2, 32'h5A5A5A5A);

    // Mid-operation reset clears everything, including regs never touched by the table.
    rst = 1'b1;
    @(posedge clk);
    #1;
    sweep_zero("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
